uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
- REQ-001: Parameter DATA_W, default 8, maximum data bits per frame (legal 5..9).
- REQ-002: Parameter FIFO_DEPTH, default 4, transmit FIFO entries (power of 2, 2..64).
- REQ-003: clk  input  1  sole clock, all logic on rising edge.
- REQ-004: rst  input  1  reset, synchronous, active-high.
- REQ-005: tx_en  input  1  write strobe; pushes tx_data_in into FIFO.
- REQ-006: tx_data_in  input  DATA_W  frame payload, LSB transmitted first.
- REQ-007: baud_div  input  32  clk cycles per bit; 0 treated as 1.
- REQ-008: data_bits  input  4  payload bits per frame; <5 clamps to 5, >DATA_W clamps to DATA_W.
- REQ-009: parity_en  input  1  insert parity bit after data.
- REQ-010: parity_odd  input  1  1=odd parity, 0=even.
- REQ-011: stop2  input  1  1=two stop bits, 0=one.
- REQ-012: tx_serial  output  1  serial line, idle high.
- REQ-013: tx_busy  output  1  high while a frame is on the line.
- REQ-014: tx_done  output  1  one-cycle pulse at end of each frame.
- REQ-015: fifo_full / fifo_empty  output  1 each  FIFO status.
- REQ-016: fifo_count  output  $clog2(FIFO_DEPTH)+1  entries held.
- REQ-017: overflow  output  1  one-cycle pulse when tx_en is dropped.

Function
- REQ-018: tx_en with fifo_full low SHALL write the FIFO that cycle; fifo_count increments next cycle.
- REQ-019: tx_en with fifo_full high SHALL drop the data and pulse overflow the next cycle; full is evaluated before any same-cycle pop.
- REQ-020: Simultaneous push and pop SHALL leave fifo_count unchanged; pointers wrap modulo FIFO_DEPTH.
- REQ-021: FSM states IDLE, START, DATA, PARITY, STOP; transitions IDLE->START on FIFO non-empty, START->DATA, DATA->PARITY (parity_en) or STOP, PARITY->STOP, STOP->START (FIFO non-empty) or IDLE.
- REQ-022: Pop and latch of data_bits/parity_en/parity_odd/stop2/baud_div SHALL occur on the IDLE->START or STOP->START transition; mid-frame config changes SHALL not affect the frame in flight.
- REQ-023: Latency: tx_en at cycle N into empty FIFO while IDLE -> tx_serial low from cycle N+2.
- REQ-024: Each bit SHALL be held exactly baud_div (latched) cycles; START drives 0, STOP drives 1.
- REQ-025: Parity bit SHALL equal XOR of transmitted data bits (even), inverted for odd.
- REQ-026: Frame length SHALL be (1 + data_bits + parity_en + 1 + stop2) x baud_div cycles.
- REQ-027: tx_busy high from first START cycle to last STOP cycle inclusive; low in IDLE.
- REQ-028: tx_done SHALL pulse in the cycle after the final stop bit period completes; back-to-back frames start START in that same cycle with no idle gap, tx_busy remaining high.

Reset
- REQ-029: While rst is high at a clk edge: tx_serial=1, tx_busy=0, tx_done=0, overflow=0, fifo_count=0, fifo_empty=1, fifo_full=0, FSM=IDLE, baud and bit counters=0.
- REQ-030: rst asserted mid-frame SHALL abort the frame, discard FIFO contents, and drive tx_serial high from the next cycle; no tx_done pulse.

Configuration
- REQ-031: Macro UART_TX_PARITY_EN defined: parity_en/parity_odd function per REQ-025.
- REQ-032: Macro UART_TX_PARITY_EN undefined: parity_en and parity_odd ignored, PARITY state never entered, frames always without parity.

Verification
- REQ-033: rst=1 two cycles -> tx_serial=1, tx_busy=0, tx_done=0, fifo_empty=1, fifo_count=0.
- REQ-034: baud_div=16, 8N1, write 0xA5 -> line 0,1,0,1,0,0,1,0,1,1 each 16 cycles, tx_done after 160 cycles from start bit.
- REQ-035: baud_div=16, 8 bits, parity_en=1 even, stop2=1, write 0x5A -> parity bit 0, two stop bits, frame 192 cycles; with parity_odd=1 parity bit 1.
- REQ-036: FIFO_DEPTH=4, five tx_en in consecutive cycles while IDLE -> fifo_full asserted, no overflow (first entry popped); sixth write while full -> overflow pulse, 5 frames sent back-to-back, 5 tx_done pulses, tx_busy never low between frames.
- REQ-037: data_bits=3, write 0x1F -> 5 data bits 1,1,1,1,1 sent (clamp); data_bits=5 frame 7x baud_div cycles.
- REQ-038: rst asserted at data bit 3 of a frame with 2 queued -> tx_serial=1 next cycle, fifo_count=0, no tx_done.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter fed by a small FIFO; frame config latched per frame.
// Define UART_TX_PARITY_EN to enable the parity bit; otherwise parity_en/parity_odd are ignored.
module uart_tx_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        tx_en,
    input  logic [DATA_W-1:0]           tx_data_in,
    input  logic [31:0]                 baud_div,
    input  logic [3:0]                  data_bits,
    input  logic                        parity_en,
    input  logic                        parity_odd,
    input  logic                        stop2,
    output logic                        tx_serial,
    output logic                        tx_busy,
    output logic                        tx_done,
    output logic                        fifo_full,
    output logic                        fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [3:0]    MAX_BITS = 4'(DATA_W);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic              push, pop, overflow_q;

    state_t            state_q, state_d;
    logic [31:0]       baud_cnt_q, baud_cnt_d, div_q, div_d, div_in;
    logic [3:0]        bit_cnt_q, bit_cnt_d, nb_q, nb_d, nb_in;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              par_q, par_d, pen_q, pen_d, odd_q, odd_d, stop2_q, stop2_d;
    logic              done_q, done_d, bit_end, pen_in, odd_in;

`ifdef UART_TX_PARITY_EN
    assign pen_in = parity_en;
    assign odd_in = parity_odd;
`else
    logic unused_parity;
    assign unused_parity = parity_en ^ parity_odd;
    assign pen_in = 1'b0;
    assign odd_in = 1'b0;
`endif

    // Full is the registered state, so a write while full drops even if a pop happens this cycle.
    assign fifo_full  = (count_q == DEPTH_C);
    assign fifo_empty = (count_q == '0);
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign push       = tx_en & ~fifo_full;
    assign count_d    = count_q + CW'(push) - CW'(pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q    <= count_d;
            overflow_q <= tx_en & fifo_full;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= tx_data_in;
    end

    always_comb begin
        nb_in = data_bits;
        if (data_bits < 4'd5)          nb_in = 4'd5;
        else if (data_bits > MAX_BITS) nb_in = MAX_BITS;
    end
    assign div_in  = (baud_div == 32'd0) ? 32'd1 : baud_div;
    assign bit_end = (baud_cnt_q == div_q - 32'd1);

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        par_d      = par_q;
        nb_d       = nb_q;
        div_d      = div_q;
        pen_d      = pen_q;
        odd_d      = odd_q;
        stop2_d    = stop2_q;
        done_d     = 1'b0;
        pop        = 1'b0;
        if (state_q != S_IDLE) baud_cnt_d = bit_end ? 32'd0 : baud_cnt_q + 32'd1;
        case (state_q)
            S_IDLE:  pop = ~fifo_empty;
            S_START: if (bit_end) state_d = S_DATA;
            S_DATA: begin
                if (bit_end) begin
                    shreg_d = shreg_q >> 1;
                    par_d   = par_q ^ shreg_q[0];
                    if (bit_cnt_q == nb_q - 4'd1) begin
                        bit_cnt_d = '0;
                        state_d   = pen_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            S_PARITY: if (bit_end) state_d = S_STOP;
            S_STOP: begin
                if (bit_end) begin
                    if (bit_cnt_q == {3'b000, stop2_q}) begin
                        done_d = 1'b1;
                        if (!fifo_empty) pop = 1'b1;
                        else             state_d = S_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Popping starts a frame and freezes its configuration until the frame ends.
        if (pop) begin
            state_d    = S_START;
            baud_cnt_d = '0;
            bit_cnt_d  = '0;
            shreg_d    = mem_q[rd_ptr_q];
            par_d      = 1'b0;
            nb_d       = nb_in;
            div_d      = div_in;
            pen_d      = pen_in;
            odd_d      = odd_in;
            stop2_d    = stop2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            nb_q       <= 4'd5;
            div_q      <= 32'd1;
            pen_q      <= 1'b0;
            odd_q      <= 1'b0;
            stop2_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            nb_q       <= nb_d;
            div_q      <= div_d;
            pen_q      <= pen_d;
            odd_q      <= odd_d;
            stop2_q    <= stop2_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        tx_serial = 1'b1;
        case (state_q)
            S_START:  tx_serial = 1'b0;
            S_DATA:   tx_serial = shreg_q[0];
            S_PARITY: tx_serial = par_q ^ odd_q;
            default:  tx_serial = 1'b1;
        endcase
    end

    assign tx_busy = (state_q != S_IDLE);
    assign tx_done = done_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo: directed frames plus random traffic.
module tb_uart_tx_fifo;
    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR_BUILD = 1'b1;
`else
    localparam bit PAR_BUILD = 1'b0;
`endif

    typedef struct {
        int div;
        int db;
        bit pen;
        bit odd;
        bit s2;
    } cfg_t;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic                        tx_en = 1'b0;
    logic [DATA_W-1:0]           tx_data_in = '0;
    logic [31:0]                 baud_div = 32'd16;
    logic [3:0]                  data_bits = 4'd8;
    logic                        parity_en = 1'b0;
    logic                        parity_odd = 1'b0;
    logic                        stop2 = 1'b0;
    logic                        tx_serial, tx_busy, tx_done, fifo_full, fifo_empty, overflow;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    int total = 0;
    int bad = 0;
    int idle_bad = 0;
    int n_push = 0, n_frames = 0, n_abort = 0, n_flush = 0, ovf_cnt = 0;
    logic [DATA_W-1:0] exp_q[$];
    cfg_t cfg_last;

    uart_tx_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst), .tx_en(tx_en), .tx_data_in(tx_data_in),
        .baud_div(baud_div), .data_bits(data_bits), .parity_en(parity_en),
        .parity_odd(parity_odd), .stop2(stop2), .tx_serial(tx_serial),
        .tx_busy(tx_busy), .tx_done(tx_done), .fifo_full(fifo_full),
        .fifo_empty(fifo_empty), .fifo_count(fifo_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, want, $time);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired, got timeout want completion at %0t", name, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DATA_W-1:0] d);
        tx_en      = 1'b1;
        tx_data_in = d;
        exp_q.push_back(d);
        n_push++;
        tick();
        tx_en = 1'b0;
    endtask

    function automatic cfg_t snap();
        cfg_t c;
        c.div = int'(baud_div);
        c.db  = int'(data_bits);
        c.pen = parity_en;
        c.odd = parity_odd;
        c.s2  = stop2;
        return c;
    endfunction

    // Reference frame: start, clamped LSB-first data, optional parity, 1 or 2 stops, each div cycles.
    task automatic run_frame();
        cfg_t c;
        logic [DATA_W-1:0] d;
        bit b[$];
        bit p;
        int nb, div, len, errs;
        c = cfg_last;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_frame: got start bit want idle line at %0t", $time);
            cfg_last = snap();
            @(negedge clk);
            return;
        end
        d   = exp_q.pop_front();
        nb  = (c.db < 5) ? 5 : ((c.db > DATA_W) ? DATA_W : c.db);
        div = (c.div == 0) ? 1 : c.div;
        p   = c.odd;
        b.push_back(1'b0);
        for (int i = 0; i < nb; i++) begin
            b.push_back(d[i]);
            p ^= d[i];
        end
        if (PAR_BUILD && c.pen) b.push_back(p);
        b.push_back(1'b1);
        if (c.s2) b.push_back(1'b1);
        len  = b.size() * div;
        errs = 0;
        for (int k = 0; k < len; k++) begin
            if (k > 0) begin
                @(negedge clk);
                if (rst !== 1'b0) begin
                    n_abort++;
                    return;
                end
            end
            if (tx_serial !== b[k / div]) errs++;
            if (tx_busy !== 1'b1) errs++;
            if (k > 0 && tx_done !== 1'b0) errs++;
            cfg_last = snap();
        end
        @(negedge clk);
        if (rst !== 1'b0) begin
            n_abort++;
            return;
        end
        chk("frame_cycle_errors", errs, 0);
        chk("frame_done_pulse", tx_done, 1);
        n_frames++;
    endtask

    initial begin : monitor
        cfg_last = snap();
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && tx_serial === 1'b0) begin
                do run_frame(); while (rst === 1'b0 && tx_serial === 1'b0);
            end else if (rst === 1'b0) begin
                if (tx_busy !== 1'b0 || tx_done !== 1'b0 || tx_serial !== 1'b1) idle_bad++;
            end
            cfg_last = snap();
        end
    end

    always @(negedge clk) if (overflow === 1'b1) ovf_cnt++;

    task automatic measure(input int div, output int len, output int waited, output logic [15:0] vec);
        int k;
        bit seen;
        len = -1;
        waited = 0;
        vec = '0;
        seen = 1'b0;
        while (!seen && waited < 4000) begin
            @(negedge clk);
            waited++;
            seen = (tx_serial === 1'b0);
        end
        if (!seen) begin
            fail("start_timeout");
            return;
        end
        k = 0;
        seen = 1'b0;
        while (!seen && k < 4000) begin
            if (k % div == div / 2 && k / div < 16) vec[k / div] = tx_serial;
            @(negedge clk);
            k++;
            seen = (tx_done === 1'b1);
        end
        if (!seen) fail("done_timeout");
        else len = k;
    endtask

    initial begin : stim
        int len, w, dn, gaps, cyc;
        logic [15:0] vec;

        repeat (2) tick();
        @(negedge clk);
        chk("rst_serial", tx_serial, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_done", tx_done, 0);
        chk("rst_empty", fifo_empty, 1);
        chk("rst_full", fifo_full, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_overflow", overflow, 0);
        tick();
        rst = 1'b0;
        tick();

        send(8'hA5);
        @(negedge clk);
        chk("lat_serial_n1", tx_serial, 1);
        chk("lat_count_n1", fifo_count, 1);
        measure(16, len, w, vec);
        chk("lat_start_cycle", w, 1);
        chk("len_8n1", len, 160);
        chk("bits_8n1_a5", vec, 16'h034A);

        data_bits = 4'd8; parity_en = 1'b1; parity_odd = 1'b0; stop2 = 1'b1;
        tick();
        send(8'h5A);
        measure(16, len, w, vec);
        chk("len_8e2", len, PAR_BUILD ? 192 : 176);
        chk("bits_8e2_5a", vec, PAR_BUILD ? 16'h0CB4 : 16'h06B4);
        parity_odd = 1'b1;
        tick();
        send(8'h5A);
        measure(16, len, w, vec);
        chk("len_8o2", len, PAR_BUILD ? 192 : 176);
        chk("bits_8o2_5a", vec, PAR_BUILD ? 16'h0EB4 : 16'h06B4);

        baud_div = 32'd2; parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0; data_bits = 4'd3;
        tick();
        send(8'h1F);
        measure(2, len, w, vec);
        chk("len_db3_clamp", len, 14);
        chk("bits_db3_clamp", vec, 16'h007E);
        data_bits = 4'd5;
        send(8'h0A);
        measure(2, len, w, vec);
        chk("len_db5", len, 14);
        chk("bits_db5", vec, 16'h0054);
        data_bits = 4'd15;
        send(8'hC3);
        measure(2, len, w, vec);
        chk("len_db15_clamp", len, 20);
        chk("bits_db15_clamp", vec, 16'h0386);
        baud_div = 32'd0; data_bits = 4'd8;
        send(8'h00);
        measure(1, len, w, vec);
        chk("len_div0", len, 10);
        chk("bits_div0", vec, 16'h0200);

        baud_div = 32'd4;
        tick();
        send(8'h3C);
        fork
            measure(4, len, w, vec);
            begin
                repeat (12) tick();
                baud_div = 32'd1; data_bits = 4'd5; stop2 = 1'b1;
            end
        join
        chk("len_cfg_change_midframe", len, 40);
        chk("bits_cfg_change_midframe", vec, 16'h0278);

        baud_div = 32'd2; data_bits = 4'd8; stop2 = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) send(8'($urandom));
        tx_en = 1'b1;
        tx_data_in = 8'hEE;
        @(negedge clk);
        chk("burst_full", fifo_full, 1);
        chk("burst_count", fifo_count, 4);
        chk("burst_no_early_ovf", overflow, 0);
        tick();
        tx_en = 1'b0;
        @(negedge clk);
        chk("burst_ovf_pulse", overflow, 1);
        tick();
        @(negedge clk);
        chk("burst_ovf_clear", overflow, 0);
        chk("burst_count_after_drop", fifo_count, 4);
        dn = 0; gaps = 0; cyc = 0;
        while (dn < 5 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (tx_done === 1'b1) dn++;
            else if (tx_busy !== 1'b1) gaps++;
        end
        chk("burst_done_pulses", dn, 5);
        chk("burst_busy_gaps", gaps, 0);
        chk("burst_busy_after", tx_busy, 0);

        baud_div = 32'd4;
        tick();
        send(8'h11);
        send(8'h22);
        send(8'h33);
        repeat (14) tick();
        @(negedge clk);
        chk("abort_count_before", fifo_count, 2);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_serial", tx_serial, 1);
        chk("abort_count", fifo_count, 0);
        chk("abort_empty", fifo_empty, 1);
        chk("abort_busy", tx_busy, 0);
        n_flush += exp_q.size();
        exp_q.delete();
        dn = 0;
        repeat (40) begin
            @(negedge clk);
            if (tx_done !== 1'b0 || tx_serial !== 1'b1) dn++;
        end
        chk("abort_quiet_line", dn, 0);

        repeat (40) begin
            baud_div   = $urandom_range(0, 3);
            data_bits  = 4'($urandom_range(0, 15));
            parity_en  = 1'($urandom);
            parity_odd = 1'($urandom);
            stop2      = 1'($urandom);
            repeat ($urandom_range(0, 25)) tick();
            if (fifo_full === 1'b0) send(8'($urandom));
            else tick();
        end

        w = 0;
        while ((exp_q.size() != 0 || tx_busy !== 1'b0) && w < 20000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 20000) fail("drain_timeout");
        repeat (3) @(negedge clk);
        chk("idle_line_errors", idle_bad, 0);
        chk("overflow_pulses", ovf_cnt, 1);
        chk("frames_accounted", n_frames + n_abort + n_flush, n_push);
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
